// File: rtl/vpu_pkg.sv
// vpu_pkg: mode-bit indices and the saturate / round-shift helpers
// shared by the vector post-processing pipeline.
package vpu_pkg;

    localparam int VPU_MODE_BIAS  = 0;
    localparam int VPU_MODE_RELU  = 1;
    localparam int VPU_MODE_QUANT = 2;
    localparam int VPU_MODE_W     = 3;
    localparam int VPU_SHIFT_W    = 5;

    // Clamp a wide signed value into an i_w-bit signed range.
    function automatic logic signed [63:0] vpu_sat(
        input logic signed [63:0] i_v,
        input int                 i_w
    );
        logic signed [63:0] w_hi;
        logic signed [63:0] w_lo;
        w_hi = (64'sd1 <<< (i_w - 1)) - 64'sd1;
        w_lo = -(64'sd1 <<< (i_w - 1));
        if (i_v > w_hi) return w_hi;
        if (i_v < w_lo) return w_lo;
        return i_v;
    endfunction

    // Arithmetic shift right, rounding half toward +inf.
    function automatic logic signed [63:0] vpu_round_shr(
        input logic signed [63:0]      i_v,
        input logic [VPU_SHIFT_W-1:0]  i_sh
    );
        logic signed [63:0] w_half;
        w_half = (i_sh == '0) ? 64'sd0 :
                 (64'sd1 <<< (i_sh - VPU_SHIFT_W'(1)));
        return (i_v + w_half) >>> i_sh;
    endfunction

endpackage

// File: rtl/vpu_bias_fifo.sv
// vpu_bias_fifo: bias-vector FIFO, power-of-2 depth,
// registered occupancy count driving full/empty.
module vpu_bias_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full     = (r_count == LP_DEPTH);
    assign o_empty    = (r_count == '0);
    assign w_push_ok  = i_push && !o_full;
    assign w_pop_ok   = i_pop && !o_empty;
    assign o_pop_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vpu_pipeline.sv
// vpu_pipeline: 3-stage bias/ReLU/quantise vector pipeline.
// Define VPU_PIPELINE_QUANT_EN to enable shift+round in stage 3.
module vpu_pipeline
    import vpu_pkg::*;
#(
    parameter int VPU_WIDTH     = 16,
    parameter int DATA_WIDTH_IN = 32,
    parameter int OUT_WIDTH     = 8,
    parameter int BIAS_DEPTH    = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [VPU_MODE_W-1:0]                   vpu_mode,
    input  logic [VPU_SHIFT_W-1:0]                  quant_shift,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [VPU_WIDTH-1:0][DATA_WIDTH_IN-1:0] in_data,
    input  logic [VPU_WIDTH-1:0]                    in_lane_mask,
    input  logic                                    bias_valid,
    output logic                                    bias_ready,
    input  logic [VPU_WIDTH-1:0][DATA_WIDTH_IN-1:0] bias_data,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [VPU_WIDTH-1:0][OUT_WIDTH-1:0]     out_data,
    output logic [VPU_WIDTH-1:0]                    out_lane_mask
);

    logic w_advance;
    logic w_accept;
    logic w_push;
    logic w_pop;
    logic w_bias_full;
    logic w_bias_empty;
    logic [VPU_WIDTH-1:0][DATA_WIDTH_IN-1:0] w_bias_head;

    logic [VPU_WIDTH-1:0][DATA_WIDTH_IN-1:0] w_s1_data;
    logic [VPU_WIDTH-1:0][DATA_WIDTH_IN-1:0] w_s2_data;
    logic [VPU_WIDTH-1:0][OUT_WIDTH-1:0]     w_s3_data;
    logic signed [63:0]                      w_s3_val;

    logic                                    r_s1_valid;
    logic [VPU_WIDTH-1:0]                    r_s1_mask;
    logic                                    r_s1_relu;
    logic [VPU_WIDTH-1:0][DATA_WIDTH_IN-1:0] r_s1_data;
    logic                                    r_s2_valid;
    logic [VPU_WIDTH-1:0]                    r_s2_mask;
    logic [VPU_WIDTH-1:0][DATA_WIDTH_IN-1:0] r_s2_data;
    logic                                    r_s3_valid;
    logic [VPU_WIDTH-1:0]                    r_s3_mask;
    logic [VPU_WIDTH-1:0][OUT_WIDTH-1:0]     r_s3_data;

    // Whole pipe freezes only when the output register is blocked.
    assign w_advance = !(r_s3_valid && !out_ready);
    assign in_ready  = !rst && w_advance &&
                       (!vpu_mode[VPU_MODE_BIAS] || !w_bias_empty);
    assign w_accept  = in_valid && in_ready;
    assign w_pop     = w_accept && vpu_mode[VPU_MODE_BIAS];

    assign bias_ready = !rst && !w_bias_full;
    assign w_push     = bias_valid && bias_ready;

    assign out_valid     = r_s3_valid && !rst;
    assign out_data      = rst ? '0 : r_s3_data;
    assign out_lane_mask = rst ? '0 : r_s3_mask;

    vpu_bias_fifo #(
        .WIDTH (VPU_WIDTH * DATA_WIDTH_IN),
        .DEPTH (BIAS_DEPTH)
    ) u_bias_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (bias_data),
        .i_pop       (w_pop),
        .o_pop_data  (w_bias_head),
        .o_full      (w_bias_full),
        .o_empty     (w_bias_empty)
    );

    always_comb begin
        w_s1_data = '0;
        for (int i = 0; i < VPU_WIDTH; i++) begin
            if (vpu_mode[VPU_MODE_BIAS])
                w_s1_data[i] = DATA_WIDTH_IN'(vpu_sat(
                    64'(signed'(in_data[i])) +
                    64'(signed'(w_bias_head[i])),
                    DATA_WIDTH_IN));
            else
                w_s1_data[i] = in_data[i];
        end
    end

    always_comb begin
        w_s2_data = '0;
        for (int i = 0; i < VPU_WIDTH; i++) begin
            if (r_s1_relu && r_s1_data[i][DATA_WIDTH_IN-1])
                w_s2_data[i] = '0;
            else
                w_s2_data[i] = r_s1_data[i];
        end
    end

`ifdef VPU_PIPELINE_QUANT_EN
    logic                   r_s1_quant;
    logic [VPU_SHIFT_W-1:0] r_s1_shift;
    logic                   r_s2_quant;
    logic [VPU_SHIFT_W-1:0] r_s2_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_quant <= 1'b0;
            r_s1_shift <= '0;
            r_s2_quant <= 1'b0;
            r_s2_shift <= '0;
        end else if (w_advance) begin
            r_s1_quant <= vpu_mode[VPU_MODE_QUANT];
            r_s1_shift <= quant_shift;
            r_s2_quant <= r_s1_quant;
            r_s2_shift <= r_s1_shift;
        end
    end
`else
    logic w_unused_quant;
    assign w_unused_quant = ^{vpu_mode[VPU_MODE_QUANT], quant_shift};
`endif

    always_comb begin
        w_s3_data = '0;
        w_s3_val  = '0;
        for (int i = 0; i < VPU_WIDTH; i++) begin
            w_s3_val = 64'(signed'(r_s2_data[i]));
`ifdef VPU_PIPELINE_QUANT_EN
            if (r_s2_quant)
                w_s3_val = vpu_round_shr(w_s3_val, r_s2_shift);
`endif
            if (r_s2_mask[i])
                w_s3_data[i] = OUT_WIDTH'(vpu_sat(w_s3_val, OUT_WIDTH));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_mask  <= '0;
            r_s1_relu  <= 1'b0;
            r_s1_data  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_mask  <= '0;
            r_s2_data  <= '0;
            r_s3_valid <= 1'b0;
            r_s3_mask  <= '0;
            r_s3_data  <= '0;
        end else if (w_advance) begin
            r_s1_valid <= w_accept;
            r_s1_mask  <= w_accept ? in_lane_mask : '0;
            r_s1_relu  <= vpu_mode[VPU_MODE_RELU];
            r_s1_data  <= w_s1_data;
            r_s2_valid <= r_s1_valid;
            r_s2_mask  <= r_s1_mask;
            r_s2_data  <= w_s2_data;
            r_s3_valid <= r_s2_valid;
            r_s3_mask  <= r_s2_mask;
            r_s3_data  <= w_s3_data;
        end
    end

endmodule

// File: tb/tb_vpu_pipeline.sv
// tb_vpu_pipeline: directed + randomized checks of vpu_pipeline
// against a lane-wise arithmetic reference model and queues.
module tb_vpu_pipeline;

    localparam int VW = 16;
    localparam int DW = 32;
    localparam int OW = 8;
    localparam int BD = 4;
    localparam longint MAXI = 64'sh7FFFFFFF;
    localparam longint MINI = -64'sh80000000;

    typedef logic [VW-1:0][DW-1:0] vec_t;
    typedef logic [VW-1:0][OW-1:0] ovec_t;
    typedef struct packed {
        ovec_t          d;
        logic [VW-1:0]  m;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    vpu_mode;
    logic [4:0]    quant_shift;
    logic          in_valid;
    logic          in_ready;
    vec_t          in_data;
    logic [VW-1:0] in_lane_mask;
    logic          bias_valid;
    logic          bias_ready;
    vec_t          bias_data;
    logic          out_valid;
    logic          out_ready;
    ovec_t         out_data;
    logic [VW-1:0] out_lane_mask;

    int checks = 0;
    int failures = 0;
    int n_out = 0;
    vec_t bq[$];
    exp_t eq[$];

    vpu_pipeline #(
        .VPU_WIDTH     (VW),
        .DATA_WIDTH_IN (DW),
        .OUT_WIDTH     (OW),
        .BIAS_DEPTH    (BD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .vpu_mode      (vpu_mode),
        .quant_shift   (quant_shift),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_lane_mask  (in_lane_mask),
        .bias_valid    (bias_valid),
        .bias_ready    (bias_ready),
        .bias_data     (bias_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_lane_mask (out_lane_mask)
    );

    always #5 clk = ~clk;

    function automatic vec_t splat(input longint v);
        vec_t r;
        for (int i = 0; i < VW; i++) r[i] = DW'(v);
        return r;
    endfunction

    function automatic ovec_t splat8(input int v);
        ovec_t r;
        for (int i = 0; i < VW; i++) r[i] = OW'(v);
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        case ($urandom_range(0, 3))
            0: w = $urandom;
            1: w = DW'($urandom_range(0, 600)) - DW'(300);
            2: w = DW'($urandom_range(0, 131072)) - DW'(65536);
            default: w = $urandom_range(0, 1) != 0 ?
                         32'h7FFFFFFF : 32'h80000000;
        endcase
        return w;
    endfunction

    // Lane-wise arithmetic of the intended transfer function.
    function automatic exp_t model(input vec_t d, input vec_t b,
                                   input logic [2:0] m,
                                   input logic [4:0] sh,
                                   input logic [VW-1:0] mk);
        exp_t   r;
        longint x;
        r = '0;
        for (int i = 0; i < VW; i++) begin
            x = longint'(signed'(d[i]));
            if (m[0]) begin
                x = x + longint'(signed'(b[i]));
                if (x > MAXI) x = MAXI;
                if (x < MINI) x = MINI;
            end
            if (m[1] && x < 0) x = 0;
`ifdef VPU_PIPELINE_QUANT_EN
            if (m[2] && sh != 0)
                x = (x + (longint'(1) <<< (sh - 1))) >>> sh;
`else
            if (sh > 5'd31) x = 0;
`endif
            if (x > 127) x = 127;
            if (x < -128) x = -128;
            r.d[i] = mk[i] ? x[OW-1:0] : '0;
        end
        r.m = mk;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lat3();
        repeat (2) begin
            @(negedge clk);
            tick();
        end
        @(negedge clk);
    endtask

    // Scoreboard: handshakes are stable from posedge+1 to next posedge.
    always @(negedge clk) begin
        logic exp_br;
        logic exp_ir;
        exp_t e;
        vec_t b;
        if (rst) begin
            bq.delete();
            eq.delete();
        end else begin
            exp_br = bq.size() < BD;
            exp_ir = !(out_valid && !out_ready) &&
                     (!vpu_mode[0] || bq.size() != 0);
            checks++;
            assert (bias_ready === exp_br) else begin
                failures++;
                $error("FAIL bias_ready obs=%b exp=%b", bias_ready, exp_br);
            end
            checks++;
            assert (in_ready === exp_ir) else begin
                failures++;
                $error("FAIL in_ready obs=%b exp=%b", in_ready, exp_ir);
            end
            if (out_valid && out_ready) begin
                n_out++;
                checks++;
                assert (eq.size() != 0) else begin
                    failures++;
                    $error("FAIL out_unexpected obs=1 exp=0");
                end
                if (eq.size() != 0) begin
                    e = eq.pop_front();
                    checks++;
                    assert (out_data === e.d && out_lane_mask === e.m)
                    else begin
                        failures++;
                        $error("FAIL out_vec obs=%h/%h exp=%h/%h",
                               out_data, out_lane_mask, e.d, e.m);
                    end
                end
            end
            if (in_valid && in_ready) begin
                b = '0;
                if (vpu_mode[0] && bq.size() != 0) b = bq.pop_front();
                eq.push_back(model(in_data, b, vpu_mode,
                                   quant_shift, in_lane_mask));
            end
            if (bias_valid && bias_ready) bq.push_back(bias_data);
        end
    end

    initial begin
        vec_t d0;
        exp_t e1;
        int   n0;
        rst = 1'b1;
        vpu_mode = '0;
        quant_shift = '0;
        in_valid = 1'b0;
        in_data = '0;
        in_lane_mask = '0;
        bias_valid = 1'b0;
        bias_data = '0;
        out_ready = 1'b1;

        repeat (2) tick();
        @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_bias_ready", 128'(bias_ready), 128'(0));
        chk("rst_out_data", 128'(out_data), 128'(0));
        chk("rst_out_mask", 128'(out_lane_mask), 128'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", 128'(in_ready), 128'(1));
        chk("rel_bias_ready", 128'(bias_ready), 128'(1));

        // Bias add, latency.
        tick();
        bias_valid = 1'b1;
        bias_data = splat(10);
        tick();
        bias_valid = 1'b0;
        vpu_mode = 3'b001;
        in_valid = 1'b1;
        in_data = splat(5);
        in_lane_mask = '1;
        @(negedge clk);
        chk("bias_accept", 128'(in_ready), 128'(1));
        tick();
        in_valid = 1'b0;
        vpu_mode = '0;
        @(negedge clk);
        chk("lat_c1", 128'(out_valid), 128'(0));
        tick();
        @(negedge clk);
        chk("lat_c2", 128'(out_valid), 128'(0));
        tick();
        @(negedge clk);
        chk("lat_c3", 128'(out_valid), 128'(1));
        chk("bias_sum15", 128'(out_data), 128'(splat8(15)));

        // ReLU with an empty bias FIFO.
        tick();
        vpu_mode = 3'b010;
        in_valid = 1'b1;
        in_data = splat(-7);
        @(negedge clk);
        chk("relu_ready", 128'(in_ready), 128'(1));
        tick();
        in_valid = 1'b0;
        vpu_mode = '0;
        lat3();
        chk("relu_valid", 128'(out_valid), 128'(1));
        chk("relu_zero", 128'(out_data), 128'(splat8(0)));

        // Quantise / saturate extremes.
        tick();
        bias_valid = 1'b1;
        bias_data = splat(24);
        tick();
        bias_data = splat(0);
        tick();
        bias_valid = 1'b0;
        vpu_mode = 3'b101;
        quant_shift = 5'd3;
        in_valid = 1'b1;
        in_data = splat(1000);
        @(negedge clk);
        chk("q_acc0", 128'(in_ready), 128'(1));
        tick();
        in_data = splat(-2000);
        @(negedge clk);
        chk("q_acc1", 128'(in_ready), 128'(1));
        tick();
        in_valid = 1'b0;
        vpu_mode = '0;
        quant_shift = '0;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("q_pos_sat", 128'(out_data), 128'(splat8(127)));
        tick();
        @(negedge clk);
        chk("q_neg_sat", 128'(out_data), 128'(splat8(-128)));

        // Bias-gated in_ready, FIFO full.
        tick();
        vpu_mode = 3'b001;
        in_valid = 1'b1;
        in_data = splat(3);
        in_lane_mask = 16'h00FF;
        @(negedge clk);
        chk("nobias_0", 128'(in_ready), 128'(0));
        tick();
        @(negedge clk);
        chk("nobias_1", 128'(in_ready), 128'(0));
        tick();
        bias_valid = 1'b1;
        bias_data = splat(-1);
        @(negedge clk);
        chk("nobias_push", 128'(in_ready), 128'(0));
        tick();
        bias_valid = 1'b0;
        @(negedge clk);
        chk("bias_arrived", 128'(in_ready), 128'(1));
        tick();
        in_valid = 1'b0;
        vpu_mode = '0;
        lat3();
        chk("mask_valid", 128'(out_valid), 128'(1));
        chk("mask_bits", 128'(out_lane_mask), 128'(16'h00FF));
        chk("mask_data", 128'(out_data),
            128'({{8{8'd0}}, {8{8'd2}}}));
        tick();
        bias_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bias_data = splat(100 + k);
            @(negedge clk);
            chk($sformatf("fill_%0d", k), 128'(bias_ready),
                128'(k < 4));
            tick();
        end
        bias_valid = 1'b0;

        // Output stall with three vectors in flight.
        out_ready = 1'b0;
        in_valid = 1'b1;
        vpu_mode = 3'b001;
        in_lane_mask = '1;
        d0 = '0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < VW; i++) in_data[i] = rand_word();
            if (k == 0) d0 = in_data;
            @(negedge clk);
            chk($sformatf("stall_fill_%0d", k), 128'(in_ready), 128'(1));
            tick();
        end
        in_valid = 1'b0;
        vpu_mode = '0;
        e1 = model(d0, splat(100), 3'b001, 5'd0, '1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("stall_valid", 128'(out_valid), 128'(1));
            chk("stall_in_ready", 128'(in_ready), 128'(0));
            chk("stall_hold", 128'(out_data), 128'(e1.d));
            tick();
        end
        out_ready = 1'b1;
        n0 = n_out;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("drain_valid", 128'(out_valid), 128'(1));
            tick();
        end
        @(negedge clk);
        chk("drain_done", 128'(out_valid), 128'(0));
        chk("drain_count", 128'(n_out - n0), 128'(3));

        // Reset mid-operation.
        tick();
        bias_valid = 1'b1;
        bias_data = splat(7);
        tick();
        bias_valid = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < VW; i++) in_data[i] = rand_word();
        tick();
        for (int i = 0; i < VW; i++) in_data[i] = rand_word();
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 128'(out_valid), 128'(0));
        chk("midrst_bias_ready", 128'(bias_ready), 128'(0));
        tick();
        rst = 1'b0;
        vpu_mode = 3'b001;
        in_valid = 1'b1;
        @(negedge clk);
        chk("postrst_valid", 128'(out_valid), 128'(0));
        chk("postrst_fifo_empty", 128'(in_ready), 128'(0));
        chk("postrst_bias_ready", 128'(bias_ready), 128'(1));
        tick();
        in_valid = 1'b0;
        vpu_mode = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("postrst_quiet", 128'(out_valid), 128'(0));
            tick();
        end

        // Randomised traffic against the scoreboard.
        for (int c = 0; c < 400; c++) begin
            in_valid = $urandom_range(0, 3) != 0;
            vpu_mode = 3'($urandom);
            quant_shift = 5'($urandom);
            in_lane_mask = VW'($urandom);
            for (int i = 0; i < VW; i++) begin
                in_data[i] = rand_word();
                bias_data[i] = rand_word();
            end
            bias_valid = $urandom_range(0, 1) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            tick();
        end
        in_valid = 1'b0;
        bias_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        chk("rand_drained", 128'(eq.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
